pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three conditions:
  - load-use hazards, by inserting a bubble into ID/EX;
  - taken branches resolved in EX, by squashing IF/ID and ID/EX;
  - multi-cycle data-memory accesses, by freezing the pipeline until dmem_ready.
- Also keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 32: width of stall_cycles and flush_count.
- LU_STALL, 1: bubbles inserted per load-use hazard. Legal range 1..3.
- MAX_WAIT, 15: consecutive memory-wait cycles before dmem_timeout is set. Must be at least 1.

Ports:
- clk, in, 1: clock, rising edge.
- rstn, in, 1: reset, asynchronous, active-low.
- id_src1, in, 5: rs1 of the instruction in ID.
- id_src2, in, 5: rs2 of the instruction in ID.
- id_uses_src2, in, 1: the ID instruction reads rs2.
- ex_dest, in, 5: destination register of the instruction in EX.
- ex_mem_r_en, in, 1: the EX instruction is a load.
- br_taken, in, 1: branch taken, resolved in EX this cycle.
- mem_access, in, 1: the MEM-stage instruction has MEM_R_EN or MEM_W_EN set.
- dmem_ready, in, 1: data memory completes the access this cycle.
- pc_en, out, 1: PC load enable.
- ifid_en, out, 1: IF/ID load enable.
- ifid_flush, out, 1: load IF/ID with zeros.
- idex_en, out, 1: ID/EX load enable.
- idex_flush, out, 1: load ID/EX with zeros (bubble: WB_EN, MEM_R_EN, MEM_W_EN = 0; EXE_CMD = encoding 0).
- exmem_en, out, 1: EX/MEM load enable.
- memwb_flush, out, 1: load MEM/WB with zeros.
- stall_cycles, out, CNT_W: count of cycles with any stall.
- flush_count, out, CNT_W: count of branch flushes.
- dmem_timeout, out, 1: sticky flag, set when a memory wait exceeds MAX_WAIT.

Behaviour:
- Reset:
  - rstn is asynchronous and active-low.
  - While rstn=0: state=RUN, lu_cnt=0, wait_cnt=0, all counters=0, dmem_timeout=0.
  - While rstn=0, outputs are forced: all *_en=0, ifid_flush=idex_flush=memwb_flush=1.
  - Reset mid-stall discards all pending stall state.
- Flush semantics: a flush input overrides the corresponding enable in the pipeline register.
- States:
  - RUN: normal flow.
  - LOAD_USE: lu_cnt>0, bubbles still owed.
  - MEM_WAIT: memory access outstanding.
- Control outputs are Mealy (state plus current inputs) so a stall takes effect in the detection cycle.
- Derived conditions:
  - mem_stall = mem_access & !dmem_ready.
  - lu_haz = ex_mem_r_en & (ex_dest!=0) & ((ex_dest==id_src1) | (id_uses_src2 & (ex_dest==id_src2))).
- Per-cycle priority, highest first:
  1. mem_stall:
     - Outputs: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, other flushes=0.
     - Next state: MEM_WAIT.
     - lu_cnt is held.
     - br_taken is ignored this cycle; the branch stays in EX and is acted on after the wait.
  2. br_taken:
     - Outputs: pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=idex_flush=1.
     - Any pending load-use bubbles are cancelled (lu_cnt=0).
     - Next state: RUN.
     - flush_count increments.
  3. State LOAD_USE, or RUN with lu_haz:
     - Outputs: pc_en=ifid_en=0, idex_flush=1, exmem_en=1.
     - On detection in RUN: lu_cnt loads LU_STALL-1. Next state is LOAD_USE if that value is >0, else RUN.
     - In LOAD_USE: lu_cnt decrements, and the FSM returns to RUN when lu_cnt reaches 0.
  4. Otherwise:
     - Outputs: all *_en=1, all flushes=0.
- MEM_WAIT:
  - wait_cnt increments each mem_stall cycle.
  - When wait_cnt reaches MAX_WAIT with the stall still active, dmem_timeout is set. It clears only on reset. The pipeline keeps waiting.
  - When dmem_ready=1 (or mem_access=0), the pipeline advances that same cycle and wait_cnt clears.
  - Exit goes to LOAD_USE if lu_cnt>0, else RUN, with priorities 2–4 re-evaluated that cycle.
- stall_cycles increments in any cycle where priority 1 or 3 applies.
- stall_cycles and flush_count saturate at all-ones.
- Register x0 (dest=0) never causes a hazard.

Test Plan:
- Load-use: ex_mem_r_en=1, ex_dest=5, id_src1=5 for one cycle with LU_STALL=1 → that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1; stall_cycles=1.
- x0 and rs2 cases:
  - ex_dest=0 with id_src1=0 and ex_mem_r_en=1 → no stall.
  - ex_dest=7, id_src2=7, id_uses_src2=0 → no stall.
  - Same with id_uses_src2=1 → stall.
- Branch: br_taken=1 for one cycle → ifid_flush=idex_flush=1, pc_en=1; flush_count=1. Branch coincident with lu_haz → no stall, stall_cycles unchanged.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 → freeze for 3 cycles (all en=0, memwb_flush=1); release on the 4th cycle; stall_cycles=3; dmem_timeout=0.
- Timeout and priority:
  - Hold the memory wait for MAX_WAIT+2 cycles → dmem_timeout=1 and stays 1 after dmem_ready.
  - br_taken asserted during the wait → no flush until release; flush occurs when br_taken is seen with no mem_stall.
- Async reset mid-stall: assert rstn=0 in MEM_WAIT with LU_STALL=3 and lu_cnt=2 → outputs forced to reset values immediately; after release, state=RUN, counters=0, no residual bubbles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status into the controller, stall/flush
// controls and performance counters back out to the pipeline registers.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_uses_src2;
  logic [4:0]       ex_dest;
  logic             ex_mem_r_en;
  logic             br_taken;
  logic             mem_access;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             dmem_timeout;

  // Pipeline side: reports hazard sources, consumes the controls
  modport master (
    output id_src1, id_src2, id_uses_src2, ex_dest, ex_mem_r_en,
           br_taken, mem_access, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, stall_cycles, flush_count, dmem_timeout
  );

  // Controller side
  modport slave (
    input  id_src1, id_src2, id_uses_src2, ex_dest, ex_mem_r_en,
           br_taken, mem_access, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, stall_cycles, flush_count, dmem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, EX branch
// squash, and freeze on multi-cycle data-memory accesses, plus perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned LU_STALL = 1,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  pipeline_hazard_ctrl_if.slave hif
);

  localparam int unsigned LU_W   = 2;
  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LOAD_USE = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              timeout_q;

  logic mem_stall;
  logic lu_haz;
  logic lu_owed;
  logic stall_evt;
  logic flush_evt;

  assign mem_stall = hif.mem_access & ~hif.dmem_ready;
  assign lu_haz    = hif.ex_mem_r_en & (hif.ex_dest != 5'd0) &
                     ((hif.ex_dest == hif.id_src1) |
                      (hif.id_uses_src2 & (hif.ex_dest == hif.id_src2)));

  // Bubbles still owed, including ones parked while a memory wait was in progress
  assign lu_owed   = (state_q == S_LOAD_USE) |
                     ((state_q == S_MEM_WAIT) & (lu_cnt_q != '0));

  assign flush_evt = ~mem_stall & hif.br_taken;
  assign stall_evt = mem_stall | (~hif.br_taken & (lu_owed | lu_haz));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Next-state: memory freeze > branch squash > load-use bubble > run
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (mem_stall) begin
      state_d = S_MEM_WAIT;
    end else if (hif.br_taken) begin
      state_d  = S_RUN;
      lu_cnt_d = '0;
    end else if (lu_owed) begin
      lu_cnt_d = lu_cnt_q - LU_W'(1);
      state_d  = (lu_cnt_q == LU_W'(1)) ? S_RUN : S_LOAD_USE;
    end else if (lu_haz) begin
      lu_cnt_d = LU_W'(LU_STALL - 1);
      state_d  = (LU_STALL > 1) ? S_LOAD_USE : S_RUN;
    end else begin
      state_d = S_RUN;
    end
  end

  // Mealy controls so a stall bites in the cycle it is detected
  always_comb begin
    hif.pc_en       = 1'b1;
    hif.ifid_en     = 1'b1;
    hif.ifid_flush  = 1'b0;
    hif.idex_en     = 1'b1;
    hif.idex_flush  = 1'b0;
    hif.exmem_en    = 1'b1;
    hif.memwb_flush = 1'b0;
    if (!rstn) begin
      hif.pc_en       = 1'b0;
      hif.ifid_en     = 1'b0;
      hif.idex_en     = 1'b0;
      hif.exmem_en    = 1'b0;
      hif.ifid_flush  = 1'b1;
      hif.idex_flush  = 1'b1;
      hif.memwb_flush = 1'b1;
    end else if (mem_stall) begin
      hif.pc_en       = 1'b0;
      hif.ifid_en     = 1'b0;
      hif.idex_en     = 1'b0;
      hif.exmem_en    = 1'b0;
      hif.memwb_flush = 1'b1;
    end else if (hif.br_taken) begin
      hif.ifid_flush  = 1'b1;
      hif.idex_flush  = 1'b1;
    end else if (lu_owed | lu_haz) begin
      hif.pc_en       = 1'b0;
      hif.ifid_en     = 1'b0;
      hif.idex_flush  = 1'b1;
    end
  end

  // Wait tracking, sticky timeout and saturating perf counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      if (mem_stall) begin
        if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end else begin
          timeout_q <= 1'b1;
        end
      end else begin
        wait_cnt_q <= '0;
      end
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_evt && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign hif.stall_cycles = stall_q;
  assign hif.flush_count  = flush_q;
  assign hif.dmem_timeout = timeout_q;

endmodule
